forwarding_scoreboard: RTL and testbench

- Parametrised hazard-detection and forwarding block for the in-order pipeline, sitting at the operand-read (ID) point.
- Owns an internal shift register of in-flight register writes, one entry per downstream stage, instead of decoding pipeline registers directly.
- Serves NUM_READ_PORTS operand reads per cycle and picks the youngest in-flight producer for each.
- Issues a stall when a producer exists but its data is not ready yet; supports pipeline freeze (memory wait), flush, and a saturating stall-cycle counter.

---
 rtl/forwarding_scoreboard.sv | 136 +++++++++++++
 tb/tb_forwarding_scoreboard.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_scoreboard.sv
// Hazard detection and operand forwarding at the ID stage.
// A shift register tracks one in-flight register write per downstream stage.
// Each read port takes its operand from the youngest matching entry.
// ID stalls while that producer's result is not available yet.
module forwarding_scoreboard #(
  parameter int NUM_READ_PORTS = 2,
  parameter int NUM_STAGES     = 3,
  parameter int REG_ADDR_W     = 5,
  parameter int DATA_W         = 32,
  parameter int FLUSH_DEPTH    = 1,
  parameter int SEL_W          = $clog2(NUM_STAGES + 1)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               issue_valid,
  input  logic                               issue_we,
  input  logic [REG_ADDR_W-1:0]              issue_addr,
  input  logic [SEL_W-1:0]                   issue_ready_at,
  input  logic                               freeze,
  input  logic                               flush,
  input  logic [NUM_READ_PORTS-1:0]          rd_en,
  input  logic [NUM_READ_PORTS*REG_ADDR_W-1:0] rd_addr,
  input  logic [NUM_READ_PORTS*DATA_W-1:0]   rf_data,
  input  logic [NUM_STAGES*DATA_W-1:0]       stage_data,
  output logic [NUM_READ_PORTS*DATA_W-1:0]   fwd_data,
  output logic [NUM_READ_PORTS-1:0]          fwd_hit,
  output logic [NUM_READ_PORTS*SEL_W-1:0]    fwd_src,
  output logic                               stall,
  output logic [15:0]                        stall_count
);

  // Source code reported when the operand comes from the register file.
  localparam logic [SEL_W-1:0] SRC_RF  = SEL_W'(NUM_STAGES);
  // The latest stage a result can become ready in; larger requests are clamped.
  localparam logic [SEL_W-1:0] MAX_RDY = SEL_W'(NUM_STAGES - 1);

  // In-flight entry fields; index 0 is the youngest instruction (EX).
  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic [REG_ADDR_W-1:0] addr_q [NUM_STAGES];
  logic [REG_ADDR_W-1:0] addr_d [NUM_STAGES];
  logic [SEL_W-1:0]      rdy_q  [NUM_STAGES];
  logic [SEL_W-1:0]      rdy_d  [NUM_STAGES];
  logic [15:0]           stall_count_q, stall_count_d;

  logic [NUM_READ_PORTS-1:0] port_stall;
  logic                      issue_fire;
  logic [SEL_W-1:0]          issue_rdy_clamped;

  // Stalling is independent of freeze, so ID sees a consistent hold request.
  assign stall             = issue_valid & (|port_stall);
  assign issue_fire        = issue_valid & ~stall & ~freeze & ~flush;
  assign issue_rdy_clamped = (issue_ready_at > MAX_RDY) ? MAX_RDY : issue_ready_at;
  assign stall_count       = stall_count_q;

  // Next state: freeze holds every entry. Otherwise entries age by one stage.
  // The slot behind them is filled by the issuing instruction or by a bubble.
  always_comb begin
    valid_d       = valid_q;
    addr_d        = addr_q;
    rdy_d         = rdy_q;
    stall_count_d = stall_count_q;
    if (!freeze) begin
      for (int k = 1; k < NUM_STAGES; k++) begin
        valid_d[k] = valid_q[k-1];
        addr_d[k]  = addr_q[k-1];
        rdy_d[k]   = rdy_q[k-1];
      end
      // Writes to the zero register are never tracked.
      valid_d[0] = issue_fire & issue_we & (issue_addr != '0);
      addr_d[0]  = issue_addr;
      rdy_d[0]   = issue_rdy_clamped;
      if (flush) begin
        for (int k = 0; k < NUM_STAGES; k++) begin
          if (k < FLUSH_DEPTH) valid_d[k] = 1'b0;
        end
      end
      if (stall && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
    end
  end

  // State registers; reset empties the pipeline tracking at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q       <= '0;
      stall_count_q <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        addr_q[k] <= '0;
        rdy_q[k]  <= '0;
      end
    end else begin
      valid_q       <= valid_d;
      stall_count_q <= stall_count_d;
      for (int k = 0; k < NUM_STAGES; k++) begin
        addr_q[k] <= addr_d[k];
        rdy_q[k]  <= rdy_d[k];
      end
    end
  end

  // Per-port lookup: the youngest valid producer of the source register wins.
  for (genvar gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_port
    logic [REG_ADDR_W-1:0] rd_a;
    logic                  active;
    logic                  hit_c;
    logic [SEL_W-1:0]      src_c;
    logic [DATA_W-1:0]     data_c;
    logic                  stall_c;

    assign rd_a   = rd_addr[gi*REG_ADDR_W +: REG_ADDR_W];
    assign active = rd_en[gi] & (rd_a != '0);

    // Scan oldest to youngest so the lowest matching index is the one kept.
    always_comb begin
      hit_c   = 1'b0;
      src_c   = SRC_RF;
      data_c  = rf_data[gi*DATA_W +: DATA_W];
      stall_c = 1'b0;
      if (active) begin
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
          if (valid_q[k] && (addr_q[k] == rd_a)) begin
            hit_c   = 1'b1;
            src_c   = SEL_W'(k);
            data_c  = stage_data[k*DATA_W +: DATA_W];
            stall_c = (SEL_W'(k) < rdy_q[k]);
          end
        end
      end
    end

    assign fwd_hit[gi]                   = hit_c;
    assign fwd_src[gi*SEL_W +: SEL_W]    = src_c;
    assign fwd_data[gi*DATA_W +: DATA_W] = data_c;
    assign port_stall[gi]                = stall_c;
  end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Self-checking bench for forwarding_scoreboard.
// The reference model is a list of in-flight writes tagged with their age.
module tb_forwarding_scoreboard;

  localparam int NP  = 2;
  localparam int NS  = 3;
  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int FD  = 1;
  localparam int SW  = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              issue_valid;
  logic              issue_we;
  logic [AW-1:0]     issue_addr;
  logic [SW-1:0]     issue_ready_at;
  logic              freeze;
  logic              flush;
  logic [NP-1:0]     rd_en;
  logic [NP*AW-1:0]  rd_addr;
  logic [NP*DW-1:0]  rf_data;
  logic [NS*DW-1:0]  stage_data;
  logic [NP*DW-1:0]  fwd_data;
  logic [NP-1:0]     fwd_hit;
  logic [NP*SW-1:0]  fwd_src;
  logic              stall;
  logic [15:0]       stall_count;

  forwarding_scoreboard #(
    .NUM_READ_PORTS(NP), .NUM_STAGES(NS), .REG_ADDR_W(AW),
    .DATA_W(DW), .FLUSH_DEPTH(FD), .SEL_W(SW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_addr(issue_addr),
    .issue_ready_at(issue_ready_at), .freeze(freeze), .flush(flush),
    .rd_en(rd_en), .rd_addr(rd_addr), .rf_data(rf_data), .stage_data(stage_data),
    .fwd_data(fwd_data), .fwd_hit(fwd_hit), .fwd_src(fwd_src),
    .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Reference model: every tracked write with its age in stages since issue.
  typedef struct {
    logic [AW-1:0] addr;
    int            rdy;
    int            age;
  } rec_t;

  rec_t        mq[$];
  logic [15:0] cnt_m = 16'd0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [15:0] cnt_snap;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // The youngest (smallest age) write to the address is the producer.
  function automatic void m_lookup(input logic [AW-1:0] a, input logic en,
                                   output bit hit, output int age, output int rdy);
    hit = 0; age = 0; rdy = 0;
    if (en && a != 0) begin
      foreach (mq[i]) begin
        if (mq[i].addr == a && (!hit || mq[i].age < age)) begin
          hit = 1; age = mq[i].age; rdy = mq[i].rdy;
        end
      end
    end
  endfunction

  task automatic idle();
    issue_valid = 0; issue_we = 0; issue_addr = '0; issue_ready_at = '0;
    freeze = 0; flush = 0; rd_en = '0; rd_addr = '0;
    rf_data = {$urandom, $urandom};
    stage_data = {$urandom, $urandom, $urandom};
  endtask

  // Inputs are already applied. Check the outputs, then clock the edge.
  // Afterwards advance the model and check the stall counter.
  task automatic run_cycle();
    bit hit;
    int ag, rd;
    bit exp_stall;
    logic [DW-1:0] ed;
    rec_t nq[$];
    int r;
    #1;
    exp_stall = 0;
    for (int p = 0; p < NP; p++) begin
      m_lookup(rd_addr[p*AW +: AW], rd_en[p], hit, ag, rd);
      ed = hit ? stage_data[ag*DW +: DW] : rf_data[p*DW +: DW];
      chk($sformatf("hit%0d", p), 64'(fwd_hit[p]), 64'(hit));
      chk($sformatf("src%0d", p), 64'(fwd_src[p*SW +: SW]), hit ? 64'(ag) : 64'(NS));
      chk($sformatf("data%0d", p), 64'(fwd_data[p*DW +: DW]), 64'(ed));
      if (hit && ag < rd) exp_stall = 1;
    end
    exp_stall = exp_stall & issue_valid;
    chk("stall", 64'(stall), 64'(exp_stall));
    $display("cyc %0d iv=%0b we=%0b a=%0d rdy=%0d frz=%0b fl=%0b en=%b ra=%0d/%0d hit=%b src=%0d/%0d stall=%0b",
             cyc, issue_valid, issue_we, issue_addr, issue_ready_at, freeze, flush, rd_en,
             rd_addr[AW-1:0], rd_addr[2*AW-1:AW], fwd_hit, fwd_src[SW-1:0], fwd_src[2*SW-1:SW], stall);
    if (!freeze) begin
      foreach (mq[i]) begin
        rec_t e;
        e = mq[i];
        e.age = e.age + 1;
        if (e.age < NS && !(flush && e.age < FD)) nq.push_back(e);
      end
      if (issue_valid && !exp_stall && !flush && issue_we && issue_addr != 0) begin
        r = (int'(issue_ready_at) > NS - 1) ? NS - 1 : int'(issue_ready_at);
        nq.push_back('{addr: issue_addr, rdy: r, age: 0});
      end
      mq = nq;
      if (exp_stall && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("stall_count", 64'(stall_count), 64'(cnt_m));
  endtask

  task automatic do_issue(input logic [AW-1:0] a, input logic [SW-1:0] rdy);
    idle();
    issue_valid = 1; issue_we = 1; issue_addr = a; issue_ready_at = rdy;
    run_cycle();
  endtask

  function automatic logic [AW-1:0] pick_addr();
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    reset_n = 0;
    idle();
    // Reset state: nothing tracked, operands come from the register file.
    issue_valid = 1; rd_en = 2'b11; rd_addr = {5'd4, 5'd8};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hit", 64'(fwd_hit), 64'd0);
    chk("rst_src", 64'(fwd_src), 64'({2'd3, 2'd3}));
    chk("rst_data", 64'(fwd_data[DW-1:0]), 64'(rf_data[DW-1:0]));
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_cnt", 64'(stall_count), 64'd0);
    reset_n = 1;

    // ALU result forwarded from EX on the next cycle.
    do_issue(5'd5, 2'd0);
    idle(); rd_en = 2'b01; rd_addr[AW-1:0] = 5'd5; stage_data[DW-1:0] = 32'h1234;
    #1;
    chk("alu_hit", 64'(fwd_hit[0]), 64'd1);
    chk("alu_src", 64'(fwd_src[SW-1:0]), 64'd0);
    chk("alu_data", 64'(fwd_data[DW-1:0]), 64'h1234);
    run_cycle();

    // Load-use: one stall cycle, then the value comes from MEM.
    do_issue(5'd8, 2'd1);
    idle(); issue_valid = 1; rd_en = 2'b01; rd_addr[AW-1:0] = 5'd8;
    #1;
    chk("lu_stall", 64'(stall), 64'd1);
    run_cycle();
    chk("lu_cnt", 64'(stall_count), 64'd1);
    #1;
    chk("lu_src", 64'(fwd_src[SW-1:0]), 64'd1);
    chk("lu_data", 64'(fwd_data[DW-1:0]), 64'(stage_data[2*DW-1:DW]));
    chk("lu_nostall", 64'(stall), 64'd0);
    run_cycle();

    // Youngest producer wins on both ports; an unmatched port reads the RF.
    do_issue(5'd3, 2'd0);
    do_issue(5'd7, 2'd0);
    do_issue(5'd3, 2'd0);
    idle(); rd_en = 2'b11; rd_addr = {5'd3, 5'd3};
    #1;
    chk("yw_src0", 64'(fwd_src[SW-1:0]), 64'd0);
    chk("yw_src1", 64'(fwd_src[2*SW-1:SW]), 64'd0);
    run_cycle();
    idle(); rd_en = 2'b10; rd_addr = {5'd9, 5'd0};
    #1;
    chk("nm_src", 64'(fwd_src[2*SW-1:SW]), 64'd3);
    chk("nm_data", 64'(fwd_data[2*DW-1:DW]), 64'(rf_data[2*DW-1:DW]));
    run_cycle();

    // Zero register is never forwarded.
    do_issue(5'd0, 2'd0);
    idle(); issue_valid = 1; rd_en = 2'b01; rf_data[DW-1:0] = '0;
    #1;
    chk("r0_hit", 64'(fwd_hit[0]), 64'd0);
    chk("r0_data", 64'(fwd_data[DW-1:0]), 64'd0);
    chk("r0_stall", 64'(stall), 64'd0);
    run_cycle();

    // Flush kills the issuing instruction; older entries keep moving.
    do_issue(5'd8, 2'd1);
    idle(); flush = 1; issue_valid = 1; issue_we = 1; issue_addr = 5'd10;
    rd_en = 2'b01; rd_addr[AW-1:0] = 5'd11;
    run_cycle();
    idle(); rd_en = 2'b11; rd_addr = {5'd10, 5'd8};
    #1;
    chk("fl_src8", 64'(fwd_src[SW-1:0]), 64'd1);
    chk("fl_hit10", 64'(fwd_hit[1]), 64'd0);
    run_cycle();

    // Freeze holds entries and the counter even while a stall is pending.
    do_issue(5'd8, 2'd1);
    cnt_snap = stall_count;
    for (int i = 0; i < 3; i++) begin
      idle(); freeze = 1; issue_valid = 1; rd_en = 2'b01; rd_addr[AW-1:0] = 5'd8;
      run_cycle();
    end
    chk("frz_cnt", 64'(stall_count), 64'(cnt_snap));
    chk("frz_src", 64'(fwd_src[SW-1:0]), 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      idle();
      issue_valid    = ($urandom_range(0, 9) < 7);
      issue_we       = ($urandom_range(0, 3) != 0);
      issue_addr     = pick_addr();
      issue_ready_at = SW'($urandom_range(0, 3));
      freeze         = ($urandom_range(0, 7) == 0);
      flush          = ($urandom_range(0, 9) == 0);
      rd_en          = NP'($urandom_range(0, 3));
      rd_addr        = {pick_addr(), pick_addr()};
      run_cycle();
    end

    // Reset between edges clears everything without a clock.
    do_issue(5'd4, 2'd1);
    idle(); issue_valid = 1; rd_en = 2'b01; rd_addr[AW-1:0] = 5'd4;
    #1;
    chk("pre_rst_stall", 64'(stall), 64'd1);
    reset_n = 0;
    #1;
    chk("mr_hit", 64'(fwd_hit), 64'd0);
    chk("mr_src", 64'(fwd_src[SW-1:0]), 64'd3);
    chk("mr_stall", 64'(stall), 64'd0);
    chk("mr_cnt", 64'(stall_count), 64'd0);
    mq.delete();
    cnt_m = 16'd0;
    #1;
    reset_n = 1;
    for (int i = 0; i < 20; i++) begin
      idle();
      issue_valid = 1; issue_we = 1; issue_addr = pick_addr();
      issue_ready_at = SW'($urandom_range(0, 2));
      rd_en = 2'b11; rd_addr = {pick_addr(), pick_addr()};
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
